imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states, sync marker default
// and the byte-lane index used while assembling little-endian words.
package imem_loader_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef logic [1:0] byte_lane_t;

    // state    | meaning
    // IDLE     | hunting for the sync byte, everything else dropped
    // LEN_LO   | expecting low byte of the word count
    // LEN_HI   | expecting high byte of the word count
    // DATA     | collecting the four bytes of the next word
    // WRITE    | one-cycle memory write, byte input stalled
    // CHECK    | expecting the checksum byte
    // DONE     | image good, processor released
    // ERROR    | image bad or timed out, processor held
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects bytes LSB first into a 32-bit word; word is complete in the same cycle the
// fourth byte is presented, so the caller can capture it on that edge.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        last
);

    byte_lane_t  lane;
    logic [23:0] low_bytes;

    assign word = {byte_data, low_bytes};
    assign last = byte_valid && (lane == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane      <= '0;
            low_bytes <= '0;
        end else if (clr) begin
            lane      <= '0;
            low_bytes <= '0;
        end else if (byte_valid) begin
            lane      <= lane + 2'd1;
            low_bytes <= {byte_data, low_bytes[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: parses sync/length/data/checksum frames, writes words into
// instruction memory and holds the processor in reset until a good image is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         MAX_WORDS      = 256,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] word_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t state, state_next;
    logic [7:0]    len_lo;
    logic [15:0]   n_words;
    logic [7:0]    acc;
    logic [TW-1:0] timer;
    logic          accept, start, timed;
    logic [31:0]   asm_word;
    logic          asm_last;

    assign accept     = rx_valid && rx_ready;
    assign rx_ready   = (state != S_WRITE);
    assign imem_we    = (state == S_WRITE);
    assign cpu_hold   = (state != S_DONE);
    assign load_done  = (state == S_DONE);
    assign load_error = (state == S_ERROR);
    assign timed      = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (start),
        .byte_valid(accept && (state == S_DATA)),
        .byte_data (rx_data),
        .word      (asm_word),
        .last      (asm_last)
    );

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_next = S_LEN_LO;
                    start      = 1'b1;
                end
            end
            S_LEN_LO: if (accept) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if ({rx_data, len_lo} == 16'd0)
                        state_next = S_CHECK;
                    else if ({rx_data, len_lo} > 16'(MAX_WORDS))
                        state_next = S_ERROR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA:  if (asm_last) state_next = S_WRITE;
            S_WRITE: state_next = (word_count + 16'd1 == n_words) ? S_CHECK : S_DATA;
            S_CHECK: if (accept) state_next = (rx_data == acc) ? S_DONE : S_ERROR;
            default: state_next = S_IDLE;
        endcase
        // A byte arriving on the expiry cycle keeps the frame alive.
        if (timed && !accept && (timer == TW'(TIMEOUT_CYCLES - 1)))
            state_next = S_ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len_lo     <= '0;
            n_words    <= '0;
            acc        <= '0;
            timer      <= '0;
            word_count <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state <= state_next;
            timer <= (!timed || accept) ? '0 : timer + TW'(1);
            if (state == S_LEN_LO && accept)
                len_lo <= rx_data;
            if (state == S_LEN_HI && accept)
                n_words <= {rx_data, len_lo};
            if (start) begin
                acc        <= '0;
                word_count <= '0;
            end else begin
                if (state == S_DATA && accept)
                    acc <= acc + rx_data;
                if (state == S_WRITE)
                    word_count <= word_count + 16'd1;
            end
            if (asm_last && state == S_DATA) begin
                imem_addr  <= {14'd0, word_count, 2'b00};
                imem_wdata <= asm_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table for whole frames plus
// hand-written sequences for timeout, async reset and full-length loads.
module tb_imem_loader;

    localparam int MAXW = 4;
    localparam int TOUT = 20;
    localparam logic [31:0] W1 = 32'h00A00513;
    localparam logic [31:0] W2 = 32'h00500593;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready, imem_we, cpu_hold, load_done, load_error;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;
    int writes = 0;

    imem_loader #(.MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_we) writes++;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        hold;
        logic        done;
        logic        err;
        logic [15:0] wc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic we, logic [31:0] addr,
                                logic [31:0] wdata, logic ready, logic hold, logic done,
                                logic err, logic [15:0] wc);
        vec_t r;
        r.v = v; r.d = d; r.we = we; r.addr = addr; r.wdata = wdata;
        r.ready = ready; r.hold = hold; r.done = done; r.err = err; r.wc = wc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Holds the byte until the loader takes it; bounded so a stuck rx_ready cannot hang.
    task automatic send(input logic [7:0] d);
        int n;
        rx_valid = 1'b1;
        rx_data  = d;
        n = 0;
        while (!rx_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) chk("send_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic chk_outputs(input string tag, input vec_t e);
        chk({tag, " we"},    32'(imem_we),    32'(e.we));
        chk({tag, " addr"},  imem_addr,       e.addr);
        chk({tag, " wdata"}, imem_wdata,      e.wdata);
        chk({tag, " ready"}, 32'(rx_ready),   32'(e.ready));
        chk({tag, " hold"},  32'(cpu_hold),   32'(e.hold));
        chk({tag, " done"},  32'(load_done),  32'(e.done));
        chk({tag, " err"},   32'(load_error), 32'(e.err));
        chk({tag, " wc"},    32'(word_count), 32'(e.wc));
    endtask

    initial begin
        int w0;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset", mk(0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0));
        reset = 1'b0;

        // Good 2-word load; data bytes sum to 0xA0. Byte held over each WRITE cycle.
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h13, 0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h05, 0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'hA0, 0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 1, 0, W1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h93, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h93, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h05, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h50, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, 1, 4, W2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 0, 4, W2, 1, 1, 0, 0, 2));
        vecs.push_back(mk(1, 8'hA0, 0, 4, W2, 1, 0, 1, 0, 2));
        vecs.push_back(mk(0, 8'h00, 0, 4, W2, 1, 0, 1, 0, 2));
        // Same frame, bad checksum 0x81.
        vecs.push_back(mk(1, 8'hA5, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h13, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h05, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'hA0, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 1, 0, W1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h93, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h93, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h05, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h50, 0, 0, W1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, 1, 4, W2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h81, 0, 4, W2, 1, 1, 0, 0, 2));
        vecs.push_back(mk(1, 8'h81, 0, 4, W2, 1, 1, 0, 1, 2));
        vecs.push_back(mk(1, 8'h00, 0, 4, W2, 1, 1, 0, 1, 2));
        // Oversize length N=257.
        vecs.push_back(mk(1, 8'hA5, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 4, W2, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 4, W2, 1, 1, 0, 1, 0));
        // Empty image N=0 with checksum 0.
        vecs.push_back(mk(1, 8'hA5, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 4, W2, 1, 0, 1, 0, 0));
        // N = MAX_WORDS+1 rejected.
        vecs.push_back(mk(1, 8'hA5, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h05, 0, 4, W2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 4, W2, 1, 1, 0, 1, 0));

        w0 = writes;
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d);
            chk_outputs($sformatf("vec%0d", i), vecs[i]);
        end
        chk("table write count", 32'(writes - w0), 32'd4);

        // Timeout: a byte on the expiry cycle wins, then a full idle window expires.
        step(1, 8'hA5); step(1, 8'h01); step(1, 8'h00);
        repeat (TOUT - 1) step(0, 8'h00);
        chk("tout pre-boundary err", 32'(load_error), 32'd0);
        step(1, 8'h13);
        chk("tout byte wins err", 32'(load_error), 32'd0);
        repeat (TOUT - 1) step(0, 8'h00);
        chk("tout window-1 err", 32'(load_error), 32'd0);
        step(0, 8'h00);
        chk("tout expired err", 32'(load_error), 32'd1);
        chk("tout expired hold", 32'(cpu_hold), 32'd1);
        step(1, 8'hA5);
        chk("tout restart err", 32'(load_error), 32'd0);
        chk("tout restart hold", 32'(cpu_hold), 32'd1);

        // Async reset mid-DATA after one word has been written.
        step(1, 8'h02); step(1, 8'h00);
        step(1, 8'h11); step(1, 8'h22); step(1, 8'h33); step(1, 8'h44);
        chk("rst pre we", 32'(imem_we), 32'd1);
        step(1, 8'h55); step(1, 8'h55);
        chk("rst pre wc", 32'(word_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_outputs("async rst", mk(0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0));
        #2 reset = 1'b0;
        step(1, 8'h00); step(1, 8'hFF);
        step(1, 8'hA5); step(1, 8'h01); step(1, 8'h00);
        step(1, 8'h11); step(1, 8'h22); step(1, 8'h33); step(1, 8'h44);
        chk_outputs("post rst write", mk(0, 8'h00, 1, 0, 32'h44332211, 0, 1, 0, 0, 0));
        step(1, 8'hAA);
        chk("post rst wc", 32'(word_count), 32'd1);
        step(1, 8'hAA);
        chk("post rst done", 32'(load_done), 32'd1);
        step(0, 8'h00);

        // Full-length image of MAX_WORDS words, bytes 1..16, checksum 0x88.
        w0 = writes;
        send(8'hA5); send(8'h04); send(8'h00);
        for (int b = 1; b <= 16; b++) send(8'(b));
        send(8'h88);
        chk("max writes", 32'(writes - w0), 32'd4);
        chk("max last addr", imem_addr, 32'h0000000C);
        chk("max last wdata", imem_wdata, 32'h100F0E0D);
        chk("max wc", 32'(word_count), 32'd4);
        chk("max done", 32'(load_done), 32'd1);
        chk("max hold", 32'(cpu_hold), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
